// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: decodes CPU read/write addresses onto N slaves, muxes read data back,
// stalls the CPU on slave wait states, times out dead reads and records the first bus error.
module dbus_interconnect #(
  parameter int              NSLV      = 3,
  parameter int              BASE_AW   = 8,
  parameter int              SLV_AW    = 14,
  parameter logic [NSLV*32-1:0] BASEADDRS = {NSLV{32'h0}},
  parameter int              TIMEOUT   = 16,
  parameter logic [31:0]     ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 dmem_rd,
  input  logic [31:0]          dmem_raddr,
  output logic [31:0]          dmem_rdata,
  input  logic                 dmem_wr,
  input  logic [31:0]          dmem_waddr,
  input  logic [31:0]          dmem_wdata,
  input  logic [3:0]           dmem_wstrb,
  output logic                 stall,
  output logic [NSLV-1:0]      slv_rd,
  output logic [SLV_AW-1:0]    slv_raddr,
  input  logic [NSLV*32-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_rvalid,
  output logic [NSLV-1:0]      slv_wr,
  output logic [SLV_AW-1:0]    slv_waddr,
  output logic [31:0]          slv_wdata,
  output logic [3:0]           slv_wstrb,
  output logic                 bus_err,
  output logic                 err_valid,
  output logic [31:0]          err_addr,
  input  logic                 err_clr
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

  state_t          state_q;
  logic [SW-1:0]   sel_q;
  logic [7:0]      cnt_q;
  logic [31:0]     raddr_q;
  logic            bus_err_q;
  logic            err_valid_q;
  logic [31:0]     err_addr_q;

  logic [NSLV-1:0] hit_r, hit_w;
  logic [SW-1:0]   rd_idx;
  logic            rvalid_sel;
  logic [31:0]     rdata_sel;
  logic            rd_accept, rd_err, wr_err, timeout;
  logic [31:0]     rd_err_addr;

  // Scanning from the top down leaves the lowest matching slave as the winner.
  function automatic logic [NSLV-1:0] decode(input logic [31:0] addr);
    logic [NSLV-1:0] oh;
    oh = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (addr[31 -: BASE_AW] == BASEADDRS[i*32+31 -: BASE_AW]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    hit_r      = decode(dmem_raddr);
    hit_w      = decode(dmem_waddr);
    rd_idx     = '0;
    rvalid_sel = 1'b0;
    rdata_sel  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit_r[i]) rd_idx = SW'(i);
      if (sel_q == SW'(i)) begin
        rvalid_sel = slv_rvalid[i];
        rdata_sel  = slv_rdata[i*32 +: 32];
      end
    end
  end

  assign rd_accept   = (state_q == S_IDLE) & dmem_rd;
  assign timeout     = (state_q == S_WAIT) & ~rvalid_sel & (cnt_q == 8'(TIMEOUT - 2));
  assign rd_err      = (rd_accept & ~|hit_r) | timeout;
  assign wr_err      = dmem_wr & ~|hit_w;
  assign rd_err_addr = (state_q == S_IDLE) ? dmem_raddr : raddr_q;

  assign slv_rd    = rd_accept ? hit_r : '0;
  assign slv_raddr = dmem_raddr[SLV_AW-1:0];
  assign slv_wr    = dmem_wr ? hit_w : '0;
  assign slv_waddr = dmem_waddr[SLV_AW-1:0];
  assign slv_wdata = dmem_wdata;
  assign slv_wstrb = dmem_wstrb;

  assign stall     = (state_q == S_WAIT) & ~rvalid_sel;
  assign bus_err   = bus_err_q;
  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;

  always_comb begin
    dmem_rdata = '0;
    if (state_q == S_ERR)                  dmem_rdata = ERR_DATA;
    else if (state_q == S_WAIT && rvalid_sel) dmem_rdata = rdata_sel;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      raddr_q     <= '0;
      bus_err_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (dmem_rd) begin
          if (|hit_r) begin
            sel_q   <= rd_idx;
            cnt_q   <= '0;
            raddr_q <= dmem_raddr;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_ERR;
          end
        end
        S_WAIT: begin
          if (rvalid_sel)   state_q <= S_IDLE;
          else if (timeout) state_q <= S_ERR;
          else              cnt_q   <= cnt_q + 8'd1;
        end
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      bus_err_q <= rd_err | wr_err;
      // A read error outranks a simultaneous write error for the captured address.
      if (err_clr) begin
        err_valid_q <= 1'b0;
        err_addr_q  <= '0;
      end else if (!err_valid_q && (rd_err || wr_err)) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= rd_err ? rd_err_addr : dmem_waddr;
      end
    end
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Bench for dbus_interconnect: three slaves at 0x1000_0000/0x2000_0000/0x3000_0000, randomized reads
// and writes checked against a transaction-level expectation model.
module tb_dbus_interconnect;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam int TMO = 16;

  logic        clk, rstn;
  logic        dmem_rd, dmem_wr, err_clr;
  logic [31:0] dmem_raddr, dmem_rdata, dmem_waddr, dmem_wdata;
  logic [3:0]  dmem_wstrb, slv_wstrb;
  logic        stall, bus_err, err_valid;
  logic [2:0]  slv_rd, slv_rvalid, slv_wr;
  logic [13:0] slv_raddr, slv_waddr;
  logic [95:0] slv_rdata;
  logic [31:0] slv_wdata, err_addr;

  int n_chk = 0;
  int n_fail = 0;
  logic        errv_m;
  logic [31:0] erra_m;

  dbus_interconnect #(
    .NSLV(3), .BASE_AW(8), .SLV_AW(14),
    .BASEADDRS({32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
    .TIMEOUT(TMO), .ERR_DATA(ERRD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .dmem_rd(dmem_rd), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_wr(dmem_wr), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .stall(stall), .slv_rd(slv_rd), .slv_raddr(slv_raddr), .slv_rdata(slv_rdata),
    .slv_rvalid(slv_rvalid), .slv_wr(slv_wr), .slv_waddr(slv_waddr), .slv_wdata(slv_wdata),
    .slv_wstrb(slv_wstrb), .bus_err(bus_err), .err_valid(err_valid), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave i owns top address byte 0x10*(i+1); the lowest index wins.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if (a[31:24] == 8'((i + 1) * 16)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 3))
      0: a[31:24] = 8'h10;
      1: a[31:24] = 8'h20;
      2: a[31:24] = 8'h30;
      default: if (ref_slave(a) >= 0) a[31:24] = 8'hF0;
    endcase
    return a;
  endfunction

  // Model of the sticky error register.
  task automatic model_err(input logic [31:0] a);
    if (!errv_m) begin
      errv_m = 1'b1;
      erra_m = a;
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    errv_m  = 1'b0;
    erra_m  = '0;
  endtask

  // Drives one CPU read; the addressed slave raises rvalid lat cycles after its strobe
  // (lat=0: never). Other slaves babble random rvalid/rdata throughout.
  task automatic run_read(input logic [31:0] addr, input int lat, input logic [31:0] dat,
                          output logic [2:0] strb, output logic [2:0] strb_late,
                          output logic [13:0] roff, output int stalls,
                          output logic [31:0] rdat, output logic berr);
    int s;
    logic [31:0] nz;
    s = ref_slave(addr);
    dmem_rd    = 1'b1;
    dmem_raddr = addr;
    nz = $urandom;
    slv_rvalid = nz[2:0];
    slv_rdata  = {$urandom, $urandom, $urandom};
    @(negedge clk);
    strb = slv_rd;
    roff = slv_raddr;
    @(posedge clk); #1;
    dmem_rd   = 1'b0;
    stalls    = 0;
    strb_late = '0;
    rdat      = 'x;
    berr      = 1'bx;
    for (int k = 1; k <= 64; k++) begin
      nz = $urandom;
      slv_rvalid = nz[2:0];
      slv_rdata  = {$urandom, $urandom, $urandom};
      if (s >= 0) begin
        slv_rvalid[s] = (k == lat);
        slv_rdata[s*32 +: 32] = dat;
      end
      @(negedge clk);
      strb_late = strb_late | slv_rd;
      if (!stall) begin
        rdat = dmem_rdata;
        berr = bus_err;
        break;
      end
      stalls++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    slv_rvalid = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; dmem_rd = 0; dmem_wr = 0; err_clr = 0;
    dmem_raddr = 0; dmem_waddr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    slv_rvalid = 0; slv_rdata = 0;
    errv_m = 0; erra_m = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (stall !== 1'b0)      begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_chk++; if (bus_err !== 1'b0)    begin n_fail++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
    n_chk++; if (err_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_err_valid: got %b want 0", err_valid); end
    n_chk++; if (err_addr !== 32'h0)  begin n_fail++; $display("FAIL rst_err_addr: got %h want 0", err_addr); end
    n_chk++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", dmem_rdata); end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (slv_rd !== 3'b000)   begin n_fail++; $display("FAIL rst_slv_rd: got %b want 000", slv_rd); end
  endtask

  task automatic test_read_basic();
    logic [2:0] st, sl; logic [13:0] ro; int ns; logic [31:0] rd, d; logic be;
    d = $urandom;
    run_read(32'h2000_0010, 1, d, st, sl, ro, ns, rd, be);
    n_chk++; if (st !== 3'b010)   begin n_fail++; $display("FAIL basic_strobe: got %b want 010", st); end
    n_chk++; if (sl !== 3'b000)   begin n_fail++; $display("FAIL basic_strobe_len: got %b want 000", sl); end
    n_chk++; if (ro !== 14'h10)   begin n_fail++; $display("FAIL basic_raddr: got %h want 0010", ro); end
    n_chk++; if (ns !== 0)        begin n_fail++; $display("FAIL basic_stalls: got %0d want 0", ns); end
    n_chk++; if (rd !== d)        begin n_fail++; $display("FAIL basic_rdata: got %h want %h", rd, d); end
    n_chk++; if (be !== 1'b0)     begin n_fail++; $display("FAIL basic_bus_err: got %b want 0", be); end
  endtask

  task automatic test_wait_states();
    logic [2:0] st, sl; logic [13:0] ro; int ns; logic [31:0] rd; logic be;
    run_read(32'h3000_0020, 4, 32'h1234_5678, st, sl, ro, ns, rd, be);
    n_chk++; if (st !== 3'b100)        begin n_fail++; $display("FAIL wait_strobe: got %b want 100", st); end
    n_chk++; if (ns !== 3)             begin n_fail++; $display("FAIL wait_stalls: got %0d want 3", ns); end
    n_chk++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_rdata: got %h want 12345678", rd); end
    @(negedge clk);
    n_chk++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL idle_rdata: got %h want 0", dmem_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_decode_err();
    logic [2:0] st, sl; logic [13:0] ro; int ns; logic [31:0] rd; logic be;
    clear_err();
    run_read(32'h0F00_0000, 1, 32'h0, st, sl, ro, ns, rd, be);
    n_chk++; if (st !== 3'b000)         begin n_fail++; $display("FAIL derr_strobe: got %b want 000", st); end
    n_chk++; if (rd !== ERRD)           begin n_fail++; $display("FAIL derr_rdata: got %h want %h", rd, ERRD); end
    n_chk++; if (be !== 1'b1)           begin n_fail++; $display("FAIL derr_bus_err: got %b want 1", be); end
    n_chk++; if (err_valid !== 1'b1)    begin n_fail++; $display("FAIL derr_err_valid: got %b want 1", err_valid); end
    n_chk++; if (err_addr !== 32'h0F00_0000) begin n_fail++; $display("FAIL derr_err_addr: got %h want 0f000000", err_addr); end
    n_chk++; if (bus_err !== 1'b0)      begin n_fail++; $display("FAIL derr_pulse_len: got %b want 0", bus_err); end
    clear_err();
    n_chk++; if (err_valid !== 1'b0)    begin n_fail++; $display("FAIL clr_err_valid: got %b want 0", err_valid); end
    n_chk++; if (err_addr !== 32'h0)    begin n_fail++; $display("FAIL clr_err_addr: got %h want 0", err_addr); end
  endtask

  task automatic test_timeout();
    logic [2:0] st, sl; logic [13:0] ro; int ns; logic [31:0] rd; logic be;
    clear_err();
    run_read(32'h1000_0000, 0, 32'h5555_AAAA, st, sl, ro, ns, rd, be);
    n_chk++; if (ns !== TMO - 1)     begin n_fail++; $display("FAIL tmo_stalls: got %0d want %0d", ns, TMO - 1); end
    n_chk++; if (rd !== ERRD)        begin n_fail++; $display("FAIL tmo_rdata: got %h want %h", rd, ERRD); end
    n_chk++; if (be !== 1'b1)        begin n_fail++; $display("FAIL tmo_bus_err: got %b want 1", be); end
    n_chk++; if (err_addr !== 32'h1000_0000) begin n_fail++; $display("FAIL tmo_err_addr: got %h want 10000000", err_addr); end
    slv_rvalid = 3'b111;
    slv_rdata  = {3{32'h5555_AAAA}};
    @(negedge clk);
    n_chk++; if ({stall, bus_err} !== 2'b00) begin n_fail++; $display("FAIL late_rvalid_flags: got %b want 00", {stall, bus_err}); end
    n_chk++; if (dmem_rdata !== 32'h0) begin n_fail++; $display("FAIL late_rvalid_rdata: got %h want 0", dmem_rdata); end
    @(posedge clk); #1;
    slv_rvalid = '0;
    clear_err();
  endtask

  task automatic test_concurrent();
    logic [31:0] wd, d;
    wd = $urandom;
    dmem_rd = 1; dmem_raddr = 32'h2000_0100;
    dmem_wr = 1; dmem_waddr = 32'h1000_0044; dmem_wdata = wd; dmem_wstrb = 4'b0011;
    slv_rvalid = '0;
    @(negedge clk);
    n_chk++; if (slv_rd !== 3'b010)   begin n_fail++; $display("FAIL conc_rd: got %b want 010", slv_rd); end
    n_chk++; if (slv_wr !== 3'b001)   begin n_fail++; $display("FAIL conc_wr: got %b want 001", slv_wr); end
    n_chk++; if (slv_wdata !== wd)    begin n_fail++; $display("FAIL conc_wdata: got %h want %h", slv_wdata, wd); end
    n_chk++; if (slv_wstrb !== 4'b0011) begin n_fail++; $display("FAIL conc_wstrb: got %b want 0011", slv_wstrb); end
    n_chk++; if (slv_waddr !== 14'h0044) begin n_fail++; $display("FAIL conc_waddr: got %h want 0044", slv_waddr); end
    @(posedge clk); #1;
    dmem_rd = 0; dmem_waddr = 32'h3000_0008;
    @(negedge clk);
    n_chk++; if (stall !== 1'b1)      begin n_fail++; $display("FAIL wait_stall: got %b want 1", stall); end
    n_chk++; if (slv_wr !== 3'b100)   begin n_fail++; $display("FAIL wait_wr: got %b want 100", slv_wr); end
    @(posedge clk); #1;
    dmem_wr = 0; d = $urandom;
    slv_rvalid = 3'b010; slv_rdata[63:32] = d;
    @(negedge clk);
    n_chk++; if ({stall, dmem_rdata} !== {1'b0, d}) begin n_fail++; $display("FAIL conc_rdata: got %b/%h want 0/%h", stall, dmem_rdata, d); end
    @(posedge clk); #1;
    slv_rvalid = '0;
  endtask

  task automatic test_random_reads();
    logic [2:0] st, sl, es; logic [13:0] ro; int ns, s, lat, en; logic [31:0] rd, d, a, ed; logic be, eb;
    clear_err();
    for (int it = 0; it < 30; it++) begin
      a = rand_addr(); d = $urandom;
      lat = $urandom_range(0, 19);
      s = ref_slave(a);
      run_read(a, lat, d, st, sl, ro, ns, rd, be);
      if (s < 0) begin
        es = 3'b000; en = 0; ed = ERRD; eb = 1'b1; model_err(a);
      end else if (lat >= 1 && lat <= TMO - 1) begin
        es = 3'(1 << s); en = lat - 1; ed = d; eb = 1'b0;
      end else begin
        es = 3'(1 << s); en = TMO - 1; ed = ERRD; eb = 1'b1; model_err(a);
      end
      n_chk++; if (st !== es) begin n_fail++; $display("FAIL rnd_strobe[%0d]: got %b want %b", it, st, es); end
      n_chk++; if (ro !== a[13:0]) begin n_fail++; $display("FAIL rnd_raddr[%0d]: got %h want %h", it, ro, a[13:0]); end
      n_chk++; if (ns !== en) begin n_fail++; $display("FAIL rnd_stalls[%0d]: got %0d want %0d", it, ns, en); end
      n_chk++; if ({be, rd} !== {eb, ed}) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %b/%h want %b/%h", it, be, rd, eb, ed); end
      n_chk++; if ({err_valid, err_addr} !== {errv_m, erra_m}) begin n_fail++; $display("FAIL rnd_errcap[%0d]: got %b/%h want %b/%h", it, err_valid, err_addr, errv_m, erra_m); end
    end
  endtask

  task automatic test_random_writes();
    logic [31:0] a; int s; logic [2:0] ew;
    clear_err();
    for (int it = 0; it < 16; it++) begin
      a = rand_addr(); s = ref_slave(a);
      ew = (s < 0) ? 3'b000 : 3'(1 << s);
      dmem_wr = 1; dmem_waddr = a; dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
      @(negedge clk);
      n_chk++; if (slv_wr !== ew) begin n_fail++; $display("FAIL wr_strobe[%0d]: got %b want %b", it, slv_wr, ew); end
      @(posedge clk); #1;
      dmem_wr = 0;
      if (s < 0) model_err(a);
      @(negedge clk);
      n_chk++; if (bus_err !== (s < 0)) begin n_fail++; $display("FAIL wr_bus_err[%0d]: got %b want %b", it, bus_err, s < 0); end
      n_chk++; if ({err_valid, err_addr} !== {errv_m, erra_m}) begin n_fail++; $display("FAIL wr_errcap[%0d]: got %b/%h want %b/%h", it, err_valid, err_addr, errv_m, erra_m); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_priority();
    clear_err();
    dmem_rd = 1; dmem_raddr = 32'h0F00_0000;
    dmem_wr = 1; dmem_waddr = 32'h4400_0000;
    @(posedge clk); #1;
    dmem_rd = 0; dmem_wr = 0;
    @(negedge clk);
    n_chk++; if (err_addr !== 32'h0F00_0000) begin n_fail++; $display("FAIL rdwr_err_addr: got %h want 0f000000", err_addr); end
    @(posedge clk); #1;
    dmem_wr = 1; dmem_waddr = 32'h5500_0000;
    @(posedge clk); #1;
    dmem_wr = 0;
    @(negedge clk);
    n_chk++; if ({bus_err, err_valid, err_addr} !== {2'b11, 32'h0F00_0000}) begin n_fail++; $display("FAIL second_err: got %b%b/%h want 11/0f000000", bus_err, err_valid, err_addr); end
    @(posedge clk); #1;
    err_clr = 1; dmem_wr = 1; dmem_waddr = 32'h6600_0000;
    @(posedge clk); #1;
    err_clr = 0; dmem_wr = 0;
    @(negedge clk);
    n_chk++; if ({err_valid, err_addr} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL clr_priority: got %b/%h want 0/0", err_valid, err_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    dmem_rd = 1; dmem_raddr = 32'h2000_0004; slv_rvalid = '0;
    @(posedge clk); #1;
    dmem_rd = 0;
    #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pre_reset_stall: got %b want 1", stall); end
    rstn = 0;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    @(negedge clk);
    rstn = 1;
    slv_rvalid = 3'b111; slv_rdata = {3{32'hCAFE_F00D}};
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if ({stall, bus_err, dmem_rdata} !== {2'b00, 32'h0}) begin n_fail++; $display("FAIL post_reset_rvalid: got %b%b/%h want 00/0", stall, bus_err, dmem_rdata); end
    @(posedge clk); #1;
    slv_rvalid = '0;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_wait_states();
    test_decode_err();
    test_timeout();
    test_concurrent();
    test_random_reads();
    test_random_writes();
    test_err_priority();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
